// File: rtl/angle_divider.sv
// Degree-angle range reduction: splits an unsigned angle into quadrant (0..3)
// and residual (0..89) degrees, registered with a one-cycle latency.
module angle_divider #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en_divider,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [1:0]            quadrant,
    output logic [DATA_WIDTH-1:0] data_out
);

    // A running remainder below 360, shifted left by one bit plus a new bit,
    // stays below 720, so 10 bits cover every input width.
    localparam int RW = 10;

    logic [RW-1:0] r360;
    logic [1:0]    quad_comb;
    logic [6:0]    res_comb;

    // Restoring long division by 360, MSB first; exact for any DATA_WIDTH.
    always_comb begin
        r360 = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            r360 = {r360[RW-2:0], data_in[i]};
            if (r360 >= RW'(360))
                r360 = r360 - RW'(360);
        end
    end

    // Boundaries at 90/180/270 go to the higher quadrant with residual 0.
    always_comb begin
        quad_comb = 2'd0;
        res_comb  = 7'(r360);
        if (r360 >= RW'(270)) begin
            quad_comb = 2'd3;
            res_comb  = 7'(r360 - RW'(270));
        end else if (r360 >= RW'(180)) begin
            quad_comb = 2'd2;
            res_comb  = 7'(r360 - RW'(180));
        end else if (r360 >= RW'(90)) begin
            quad_comb = 2'd1;
            res_comb  = 7'(r360 - RW'(90));
        end
    end

    // reset_n is active-high despite its name.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            quadrant <= 2'd0;
            data_out <= '0;
        end else if (en_divider) begin
            quadrant <= quad_comb;
            data_out <= DATA_WIDTH'(res_comb);
        end
    end

endmodule

// File: tb/tb_angle_divider.sv
// Directed bench for angle_divider: reset, sweep, random, enable gating,
// upper-range values and asynchronous reset.
module tb_angle_divider;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en_divider;
    logic [DW-1:0] data_in;
    logic [1:0]    quadrant;
    logic [DW-1:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;

    angle_divider #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_divider (en_divider),
        .data_in    (data_in),
        .quadrant   (quadrant),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int q, input int r);
        check_val({tag, "_q"}, int'(quadrant), q);
        check_val({tag, "_r"}, int'(data_out), r);
    endtask

    // Present a sample on the falling edge, let one rising edge load it.
    task automatic apply(input int a);
        @(negedge clk);
        data_in    = DW'(a);
        en_divider = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Hand-computed vectors: angle, quadrant, residual.
    int vec_a [13] = '{0, 85, 90, 180, 185, 270, 275, 355, 360, 455, 720, 65535, 65520};
    int vec_q [13] = '{0, 0,  1,  2,   2,   3,   3,   3,   0,   1,   0,   0,     0};
    int vec_r [13] = '{0, 85, 0,  0,   5,   0,   5,   85,  0,   5,   0,   15,    0};

    initial begin
        int a;
        reset_n    = 1'b1;
        en_divider = 1'b1;
        data_in    = DW'(135);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_out("reset_hold", 0, 0);
        end

        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_out("reset_release", 0, 0);
        @(posedge clk);
        #1;
        check_out("after_release", 1, 45);

        for (int i = 0; i < 13; i++) begin
            apply(vec_a[i]);
            check_out($sformatf("vec_%0d", vec_a[i]), vec_q[i], vec_r[i]);
        end

        for (int v = 0; v <= 720; v += 5) begin
            apply(v);
            check_out($sformatf("sweep_%0d", v), (v % 360) / 90, v % 90);
        end

        for (int i = 0; i < 24; i++) begin
            a = int'($urandom_range(719));
            apply(a);
            check_out($sformatf("rand_%0d", a), (a % 360) / 90, a % 90);
        end

        apply(200);
        check_out("gate_load", 2, 20);
        @(negedge clk);
        en_divider = 1'b0;
        data_in    = DW'(30);
        repeat (2) @(posedge clk);
        #1;
        check_out("gate_hold", 2, 20);
        apply(30);
        check_out("gate_resume", 0, 30);

        apply(300);
        check_out("pre_async", 3, 30);
        @(negedge clk);
        data_in = DW'(135);
        #2;
        reset_n = 1'b1;
        #1;
        check_out("async_reset", 0, 0);
        @(posedge clk);
        #1;
        check_out("async_held", 0, 0);
        reset_n = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
